// File: rtl/fa_clk_ctrl.sv
// Clock-path control for the fulladder datapath: functional clock gating with drain hold,
// plus a shift/capture/unload scan sequencer. Every output comes straight from a flop.
module fa_clk_ctrl #(
    parameter int CNT_W    = 8,
    parameter int PAT_W    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Func_req,
    input  logic             Scan_start,
    input  logic [CNT_W-1:0] Shift_len,
    input  logic [PAT_W-1:0] Pattern_cnt,
    output logic             Scan_en,
    output logic             cg_en,
    output logic             Busy,
    output logic             Done,
    output logic             Start_err
);

    // state   | meaning
    // IDLE    | clock gated off, waiting for Func_req or Scan_start
    // FUNC    | functional clock running while Func_req is high
    // DRAIN   | clock held HOLD_CYC cycles so the pipeline empties
    // SHIFT   | scan load, Shift_len cycles with Scan_en high
    // CAPTURE | one functional capture cycle, consumes one pattern
    // UNLOAD  | final scan unload, Shift_len cycles, then Done
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FUNC    = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_UNLOAD  = 3'd5;

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  shift_cnt, shift_cnt_nx;
    logic [CNT_W-1:0]  len_q, len_nx;
    logic [PAT_W-1:0]  pat_q, pat_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic              done_nx;

    // Down-counters are loaded with N-1 so a segment ends on terminal count zero,
    // which keeps the maximum lengths exact without an extra counter bit.
    always_comb begin
        state_nx     = state;
        shift_cnt_nx = shift_cnt;
        len_nx       = len_q;
        pat_nx       = pat_q;
        hold_nx      = hold_cnt;
        done_nx      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Scan_start) begin
                    len_nx = Shift_len;
                    pat_nx = Pattern_cnt;
                    if (Pattern_cnt == '0) begin
                        done_nx = 1'b1;
                    end else if (Shift_len == '0) begin
                        state_nx = ST_CAPTURE;
                    end else begin
                        state_nx     = ST_SHIFT;
                        shift_cnt_nx = Shift_len - CNT_W'(1);
                    end
                end else if (Func_req) begin
                    state_nx = ST_FUNC;
                end
            end
            ST_FUNC: begin
                if (!Func_req) begin
                    if (HOLD_CYC == 0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_DRAIN;
                        hold_nx  = HOLD_LD;
                    end
                end
            end
            ST_DRAIN: begin
                if (Func_req) begin
                    state_nx = ST_FUNC;
                end else if (hold_cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    hold_nx = hold_cnt - HOLD_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift_cnt == '0) begin
                    state_nx = ST_CAPTURE;
                end else begin
                    shift_cnt_nx = shift_cnt - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                pat_nx = pat_q - PAT_W'(1);
                if (pat_q == PAT_W'(1)) begin
                    if (len_q == '0) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx     = ST_UNLOAD;
                        shift_cnt_nx = len_q - CNT_W'(1);
                    end
                end else if (len_q != '0) begin
                    state_nx     = ST_SHIFT;
                    shift_cnt_nx = len_q - CNT_W'(1);
                end
            end
            ST_UNLOAD: begin
                if (shift_cnt == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    shift_cnt_nx = shift_cnt - CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            shift_cnt <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            hold_cnt  <= '0;
            Scan_en   <= 1'b0;
            cg_en     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Start_err <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_cnt <= shift_cnt_nx;
            len_q     <= len_nx;
            pat_q     <= pat_nx;
            hold_cnt  <= hold_nx;
            Scan_en   <= (state_nx == ST_SHIFT) || (state_nx == ST_UNLOAD);
            cg_en     <= (state_nx != ST_IDLE);
            Busy      <= (state_nx != ST_IDLE);
            Done      <= done_nx;
            Start_err <= Scan_start && (state != ST_IDLE);
        end
    end

endmodule
